// File: rtl/writeback_arbiter_pkg.sv
// Shared widths and the buffered write-back entry layout.
package writeback_arbiter_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned NREGS  = 32;

    // One buffered MDU result: destination register and its data (37 bits).
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [WORD_W-1:0] data;
    } wb_entry_t;

endpackage : writeback_arbiter_pkg

// File: rtl/writeback_arbiter_wb_fifo.sv
// Synchronous FIFO for MDU results; the extra pointer bit separates full from empty.
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_push,
    input  wb_entry_t i_data,
    input  logic      i_pop,
    output wb_entry_t o_head_c,
    output logic      o_full_c,
    output logic      o_empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty_c = (r_wptr == r_rptr);
    assign o_full_c  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                       (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_push    = i_push && !o_full_c;
    assign w_pop     = i_pop && !o_empty_c;
    assign o_head_c  = r_mem[r_rptr[PTR_W-1:0]];

    // Pointer update; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= i_data;
    end

endmodule : wb_fifo

// File: rtl/writeback_arbiter.sv
// Merges ALU and buffered MDU results onto the register-file write port and
// tracks registers that still await an MDU result.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aluValid,
    input  logic [REG_W-1:0]  aluReg,
    input  logic [WORD_W-1:0] aluData,
    input  logic              mduIssue,
    input  logic [REG_W-1:0]  mduIssueReg,
    input  logic              mduValid,
    input  logic [REG_W-1:0]  mduReg,
    input  logic [WORD_W-1:0] mduData,
    output logic              mduReady,
    output logic              regWrite,
    output logic [REG_W-1:0]  writeReg,
    output logic [WORD_W-1:0] writeData,
    output logic [NREGS-1:0]  pendingMask,
    output logic              conflictErr
);

    logic              r_reg_write;
    logic [REG_W-1:0]  r_write_reg;
    logic [WORD_W-1:0] r_write_data;
    logic [NREGS-1:0]  r_pending;
    logic              r_conflict;

    wb_entry_t         w_head;
    wb_entry_t         w_push_data;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_conflict;
    logic [NREGS-1:0]  w_pending_next;

    assign mduReady    = !w_full && !reset;
    assign w_push      = mduValid && mduReady;
    assign w_pop       = !aluValid && !w_empty && !reset;
    assign w_push_data = '{rd: mduReg, data: mduData};
    assign w_conflict  = aluValid && (aluReg != '0) && r_pending[aluReg];

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_data    (w_push_data),
        .i_pop     (w_pop),
        .o_head_c  (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    // Scoreboard next state: a pop clears, a new issue sets, and set wins a tie.
    always_comb begin
        w_pending_next = r_pending;
        if (w_pop) w_pending_next[w_head.rd] = 1'b0;
        if (mduIssue && (mduIssueReg != '0)) w_pending_next[mduIssueReg] = 1'b1;
    end

    // Write-port arbitration with ALU priority; idle cycles hold address/data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else if (aluValid) begin
            r_reg_write  <= (aluReg != '0);
            r_write_reg  <= aluReg;
            r_write_data <= aluData;
        end else if (w_pop) begin
            r_reg_write  <= (w_head.rd != '0);
            r_write_reg  <= w_head.rd;
            r_write_data <= w_head.data;
        end else begin
            r_reg_write  <= 1'b0;
        end
    end

    // Scoreboard and sticky ordering-violation flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_pending  <= w_pending_next;
            if (w_conflict) r_conflict <= 1'b1;
        end
    end

    assign regWrite    = r_reg_write;
    assign writeReg    = r_write_reg;
    assign writeData   = r_write_data;
    assign pendingMask = r_pending;
    assign conflictErr = r_conflict;

endmodule : writeback_arbiter

// File: tb/tb_writeback_arbiter.sv
// Randomized bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int DEPTH  = 4;
    localparam int CYCLES = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        aluValid;
    logic [4:0]  aluReg;
    logic [31:0] aluData;
    logic        mduIssue;
    logic [4:0]  mduIssueReg;
    logic        mduValid;
    logic [4:0]  mduReg;
    logic [31:0] mduData;
    logic        mduReady;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [31:0] pendingMask;
    logic        conflictErr;

    writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .aluValid    (aluValid),
        .aluReg      (aluReg),
        .aluData     (aluData),
        .mduIssue    (mduIssue),
        .mduIssueReg (mduIssueReg),
        .mduValid    (mduValid),
        .mduReg      (mduReg),
        .mduData     (mduData),
        .mduReady    (mduReady),
        .regWrite    (regWrite),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .pendingMask (pendingMask),
        .conflictErr (conflictErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned r;
        logic [31:0] d;
    } ent_t;

    // Reference state: buffered results, pending set, and expected port values.
    ent_t        q[$];
    bit          pend[32];
    bit          exp_we;
    int unsigned exp_reg;
    logic [31:0] exp_data;
    bit          exp_conf;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%08h exp=%08h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pend_word();
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) w[i] = pend[i];
        return w;
    endfunction

    // Apply one clock edge worth of specified behaviour to the model.
    task automatic model_step(output bit pushed);
        bit   ready = (reset == 1'b0) && (q.size() < DEPTH);
        ent_t e;
        pushed = mduValid && ready;
        if (reset) begin
            q.delete();
            for (int i = 0; i < 32; i++) pend[i] = 0;
            exp_we = 0; exp_reg = 0; exp_data = '0; exp_conf = 0;
            return;
        end
        if (aluValid) begin
            if (aluReg != 0 && pend[aluReg]) exp_conf = 1;
            exp_we   = (aluReg != 0);
            exp_reg  = aluReg;
            exp_data = aluData;
        end else if (q.size() > 0) begin
            e        = q.pop_front();
            exp_we   = (e.r != 0);
            exp_reg  = e.r;
            exp_data = e.d;
            pend[e.r] = 0;
        end else begin
            exp_we = 0;
        end
        if (mduIssue && mduIssueReg != 0) pend[mduIssueReg] = 1;
        if (pushed) begin
            e.r = mduReg;
            e.d = mduData;
            q.push_back(e);
        end
    endtask

    initial begin
        bit  pushed;
        bit  hold;
        int  alu_pct;
        int  mdu_pct;

        reset = 1'b1;
        aluValid = 0; aluReg = '0; aluData = '0;
        mduIssue = 0; mduIssueReg = '0;
        mduValid = 0; mduReg = '0; mduData = '0;
        hold = 0;

        @(negedge clk);
        check_val("ready_in_reset", 32'(mduReady), 32'd0);
        model_step(pushed);

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            check_val("regWrite",    32'(regWrite),    32'(exp_we));
            check_val("writeReg",    32'(writeReg),    32'(exp_reg));
            check_val("writeData",   writeData,        exp_data);
            check_val("pendingMask", pendingMask,      pend_word());
            check_val("conflictErr", 32'(conflictErr), 32'(exp_conf));

            // Phase-dependent traffic mix: heavy ALU phases fill the buffer, light ones drain it.
            case ((cyc / 150) % 4)
                0:       begin alu_pct = 30;  mdu_pct = 40; end
                1:       begin alu_pct = 100; mdu_pct = 80; end
                2:       begin alu_pct = 0;   mdu_pct = 50; end
                default: begin alu_pct = 85;  mdu_pct = 60; end
            endcase

            reset    = (cyc < 2) || ($urandom_range(0, 199) == 0);
            aluValid = ($urandom_range(0, 99) < alu_pct);
            aluReg   = 5'($urandom_range(0, 15));
            aluData  = $urandom;
            mduIssue = ($urandom_range(0, 99) < 40);
            mduIssueReg = 5'($urandom_range(0, 15));
            if (!hold) begin
                mduValid = ($urandom_range(0, 99) < mdu_pct);
                mduReg   = 5'($urandom_range(0, 15));
                mduData  = $urandom;
            end

            @(negedge clk);
            check_val("mduReady", 32'(mduReady),
                      32'((reset == 1'b0) && (q.size() < DEPTH)));
            model_step(pushed);
            // Producer keeps an unaccepted offer stable until it transfers.
            hold = mduValid && !pushed && !reset;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_writeback_arbiter
